// File: rtl/sb_rx_msg_engine.sv
// Sideband receive message engine: decodes deserialised header/data packets,
// checks parity and opcode, and queues complete messages in a show-ahead
// FIFO. A separate pattern mode counts consecutive start-pattern packets.
module sb_rx_msg_engine #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PAT_CNT    = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_pattern_mode,
  input  logic                          i_deser_valid,
  input  logic [63:0]                   i_deser_data,
  output logic                          o_pattern_detected,
  output logic                          o_msg_valid,
  input  logic                          i_msg_ready,
  output logic [3:0]                    o_msg_no,
  output logic [2:0]                    o_msg_info,
  output logic                          o_msg_has_data,
  output logic [DATA_W-1:0]             o_msg_data,
  output logic                          o_parity_error,
  output logic                          o_opcode_error,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int         AW        = $clog2(FIFO_DEPTH);
  localparam int         CW        = AW + 1;
  localparam logic [4:0] OP_NODATA = 5'b10010;
  localparam logic [4:0] OP_DATA   = 5'b11011;
  localparam logic [63:0] PAT_WORD = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [3:0] PAT_TGT   = 4'(PAT_CNT);

  typedef enum logic [1:0] {WAIT_HDR, WAIT_DATA, PATTERN} state_e;

  typedef struct packed {
    logic [3:0]        no;
    logic [2:0]        info;
    logic              has_data;
    logic [DATA_W-1:0] data;
  } msg_t;

  state_e        state_q, state_d;
  logic [3:0]    hdr_no_q;
  logic [2:0]    hdr_info_q;
  logic          hdr_dp_q;
  logic          hdr_ld;
  logic [3:0]    cnt_q, cnt_d;
  logic          det_q, det_d;
  logic          perr_q, perr_d;
  logic          oerr_q, oerr_d;
  logic          ovf_q;
  logic          enq;
  msg_t          enq_msg;

  msg_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic          full, pop, push_ok;
  msg_t          head;

  logic [4:0]    opcode;
  logic          cp_ok, dp_ok;

  assign opcode = i_deser_data[4:0];
  assign cp_ok  = ((^i_deser_data[61:0]) == i_deser_data[62]);
  assign dp_ok  = ((^i_deser_data) == hdr_dp_q);

  // Next-state, enqueue request, error pulses and pattern counter.
  always_comb begin
    state_d  = state_q;
    hdr_ld   = 1'b0;
    enq      = 1'b0;
    enq_msg  = '0;
    perr_d   = 1'b0;
    oerr_d   = 1'b0;
    cnt_d    = cnt_q;
    det_d    = det_q;
    if (i_pattern_mode) begin
      // Any pending header is simply abandoned; the queue is untouched.
      state_d = PATTERN;
      if (state_q == PATTERN && i_deser_valid) begin
        if (i_deser_data == PAT_WORD) begin
          if (cnt_q < PAT_TGT) cnt_d = cnt_q + 4'd1;
          if (cnt_d == PAT_TGT) det_d = 1'b1;
        end else begin
          cnt_d = '0;
        end
      end
    end else begin
      case (state_q)
        WAIT_HDR: begin
          if (i_deser_valid) begin
            if (!cp_ok) begin
              perr_d = 1'b1;
            end else if (opcode == OP_NODATA) begin
              enq           = 1'b1;
              enq_msg.no    = i_deser_data[11:8];
              enq_msg.info  = i_deser_data[14:12];
            end else if (opcode == OP_DATA) begin
              hdr_ld  = 1'b1;
              state_d = WAIT_DATA;
            end else begin
              oerr_d = 1'b1;
            end
          end
        end
        WAIT_DATA: begin
          if (i_deser_valid) begin
            state_d = WAIT_HDR;
            if (dp_ok) begin
              enq              = 1'b1;
              enq_msg.no       = hdr_no_q;
              enq_msg.info     = hdr_info_q;
              enq_msg.has_data = 1'b1;
              enq_msg.data     = i_deser_data[DATA_W-1:0];
            end else begin
              perr_d = 1'b1;
            end
          end
        end
        PATTERN: begin
          state_d = WAIT_HDR;
          cnt_d   = '0;
          det_d   = 1'b0;
        end
        default: state_d = WAIT_HDR;
      endcase
    end
  end

  // FSM state, latched header fields, pattern tracking and error pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= WAIT_HDR;
      hdr_no_q   <= '0;
      hdr_info_q <= '0;
      hdr_dp_q   <= 1'b0;
      cnt_q      <= '0;
      det_q      <= 1'b0;
      perr_q     <= 1'b0;
      oerr_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      det_q   <= det_d;
      perr_q  <= perr_d;
      oerr_q  <= oerr_d;
      if (hdr_ld) begin
        hdr_no_q   <= i_deser_data[11:8];
        hdr_info_q <= i_deser_data[14:12];
        hdr_dp_q   <= i_deser_data[63];
      end
    end
  end

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = o_msg_valid & i_msg_ready;
  // A full queue still accepts when the head leaves on the same edge.
  assign push_ok = enq & (~full | pop);

  // Queue pointers, occupancy and sticky overflow flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      if (enq && full && !pop) ovf_q <= 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Queue storage; contents are only visible through the valid-gated head.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_q] <= enq_msg;
  end

  assign head               = mem[rd_q];
  assign o_msg_valid        = (count_q != '0);
  assign o_msg_no           = o_msg_valid ? head.no       : '0;
  assign o_msg_info         = o_msg_valid ? head.info     : '0;
  assign o_msg_has_data     = o_msg_valid ? head.has_data : 1'b0;
  assign o_msg_data         = o_msg_valid ? head.data     : '0;
  assign o_fifo_count       = count_q;
  assign o_overflow         = ovf_q;
  assign o_parity_error     = perr_q;
  assign o_opcode_error     = oerr_q;
  assign o_pattern_detected = det_q;

endmodule
